mil_word_fifo: RTL

Parametrised, buffered MIL-STD-1553 word sink/source between a push-side producer (transceiver receive path or test helper) and a pop-side consumer (SPI bridge or bench). Accepts words on an `IPushMil` slave port, stores up to `DEPTH` typed words, and serves them on an `IPopMil` slave port. Pop requests against an empty buffer are held until a word arrives. It also tracks fill level, overflow and error-word statistics. It replaces the unbuffered, print-and-acknowledge debug sink.

---
 rtl/mil_word_fifo_if.sv | 36 +++
 rtl/mil_word_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mil_word_fifo_if.sv
// MIL-STD-1553 word types and the push/pop handshake interfaces.
// Handshake: master raises request, slave answers with a one-cycle done.

package mil_pkg;
   typedef enum logic [1:0] {
      WSERV    = 2'd0,
      WDATA    = 2'd1,
      WSERVERR = 2'd2,
      WDATAERR = 2'd3
   } mil_type_e;

   typedef struct packed {
      mil_type_e   dataType;
      logic [15:0] dataWord;
   } mil_word_t;
endpackage

interface IPushMil;
   import mil_pkg::*;
   logic      request;
   logic      done;
   mil_word_t data;

   modport master (output request, output data, input done);
   modport slave  (input request, input data, output done);
endinterface

interface IPopMil;
   import mil_pkg::*;
   logic      request;
   logic      done;
   mil_word_t data;

   modport master (output request, input data, input done);
   modport slave  (input request, output data, output done);
endinterface

// File: rtl/mil_word_fifo.sv
// Buffered MIL-STD-1553 word sink/source: circular buffer between a push
// producer and a pop consumer, with fill level, overflow and error stats.
// Build option MIL_FIFO_ERRDROP_EN: error-typed words are counted but not stored.
//
// Pop FSM
//   state | meaning
//   IDLE  | no pop in progress; a registered request is served here
//   WAIT  | pop requested against an empty buffer, waiting for a word
//   OUT   | word dequeued into pop.data, pop.done high this cycle

module mil_word_fifo
   import mil_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int STATW = 16
) (
   input  logic                       clk,
   input  logic                       nRst,
   IPushMil.slave                     push,
   IPopMil.slave                      pop,
   input  logic                       clr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [STATW-1:0]           ovfCnt,
   output logic [STATW-1:0]           errCnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {IDLE, WAIT, OUT} pop_state_e;

   pop_state_e       state_q, state_d;
   mil_word_t        mem [DEPTH];
   mil_word_t        pop_data_q;
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic [STATW-1:0] ovf_cnt_q, err_cnt_q;
   logic             ovf_q;
   logic             push_done_q;
   logic             req_q;
   logic             deq, wr, drop, is_err, store_req;

   assign is_err = (push.data.dataType == WDATAERR) || (push.data.dataType == WSERVERR);

`ifdef MIL_FIFO_ERRDROP_EN
   assign store_req = push.request && !is_err;
`else
   assign store_req = push.request;
`endif

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // A write into a full buffer is still accepted when a dequeue frees a slot.
   assign wr   = store_req && (!full || deq) && !clr;
   assign drop = store_req && full && !deq && !clr;

   assign count     = count_q;
   assign overflow  = ovf_q;
   assign ovfCnt    = ovf_cnt_q;
   assign errCnt    = err_cnt_q;
   assign push.done = push_done_q;
   assign pop.done  = (state_q == OUT);
   assign pop.data  = pop_data_q;

   // Pop FSM next state and dequeue strobe; clr cancels any pending pop.
   always_comb begin
      state_d = state_q;
      deq     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_q) begin
               if (!empty) begin
                  deq     = 1'b1;
                  state_d = OUT;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!empty) begin
               deq     = 1'b1;
               state_d = OUT;
            end
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d = IDLE;
         deq     = 1'b0;
      end
   end

   // FSM state and pop request capture; requests outside IDLE are ignored.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= pop.request && (state_q == IDLE) && !clr;
      end
   end

   // Storage array; no reset needed, validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (wr) mem[wptr_q] <= push.data;
   end

   // Pointers, fill level and the pop output register.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         pop_data_q <= '0;
      end else if (clr) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr)  wptr_q <= wptr_q + AW'(1);
         if (deq) begin
            rptr_q     <= rptr_q + AW'(1);
            pop_data_q <= mem[rptr_q];
         end
         count_q <= count_q + CW'(wr) - CW'(deq);
      end
   end

   // Push acknowledge: every sampled request is answered, dropped or not.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) push_done_q <= 1'b0;
      else       push_done_q <= push.request;
   end

   // Overflow flag and saturating overflow/error counters.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
         err_cnt_q <= '0;
      end else if (clr) begin
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + STATW'(1);
         end
         if (push.request && is_err && (err_cnt_q != '1))
            err_cnt_q <= err_cnt_q + STATW'(1);
      end
   end

endmodule
